// File: rtl/regfile_pkg.sv
// Shared constants for the two-write/two-read register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    localparam logic MODE_OVR = 1'b0;
    localparam logic MODE_ACC = 1'b1;

endpackage

// File: rtl/regcell.sv
// One register word with synchronous reset and enable-qualified load.
module regcell
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wsel,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] value_q;

    always_comb begin
        value_d = value_q;
        if (rst) begin
            value_d = '0;
        end else if (en && wsel) begin
            value_d = d_in;
        end
    end

    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

    assign q_out = value_q;

endmodule

// File: rtl/regfile_2w2r.sv
// Register file with two arbitrated write ports (overwrite/accumulate) and
// two registered write-first read ports.
module regfile_2w2r
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we1,
    input  logic             mode1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] in1,
    input  logic             we2,
    input  logic             mode2,
    input  logic [AW-1:0]    waddr2,
    input  logic [WIDTH-1:0] in2,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             collision
);

    logic [WIDTH-1:0] word_q   [DEPTH];
    logic [WIDTH-1:0] word_nxt [DEPTH];
    logic [DEPTH-1:0] wsel;
    logic             coll_hit;
    logic [WIDTH-1:0] rd1_nxt;
    logic [WIDTH-1:0] rd2_nxt;

    logic [WIDTH-1:0] out1_d, out1_q;
    logic [WIDTH-1:0] out2_d, out2_q;
    logic             collision_d, collision_q;

    // Per-word arbitration: port 2 wins a shared address; out-of-range
    // addresses match no word and are therefore dropped.
    always_comb begin
        logic hit1;
        logic hit2;
        wsel     = '0;
        coll_hit = 1'b0;
        hit1     = 1'b0;
        hit2     = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            word_nxt[i] = word_q[i];
            hit1 = we1 && (waddr1 == AW'(i));
            hit2 = we2 && (waddr2 == AW'(i));
            if (hit2) begin
                wsel[i]     = 1'b1;
                word_nxt[i] = (mode2 == MODE_ACC) ? word_q[i] + in2 : in2;
            end else if (hit1) begin
                wsel[i]     = 1'b1;
                word_nxt[i] = (mode1 == MODE_ACC) ? word_q[i] + in1 : in1;
            end
            if (hit1 && hit2) begin
                coll_hit = 1'b1;
            end
        end
    end

    // Read muxes tap the post-write values so reads are write-first.
    always_comb begin
        rd1_nxt = '0;
        rd2_nxt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (raddr1 == AW'(i)) rd1_nxt = word_nxt[i];
            if (raddr2 == AW'(i)) rd2_nxt = word_nxt[i];
        end
    end

    always_comb begin
        out1_d      = out1_q;
        out2_d      = out2_q;
        collision_d = collision_q;
        if (rst) begin
            out1_d      = '0;
            out2_d      = '0;
            collision_d = 1'b0;
        end else if (en) begin
            out1_d      = rd1_nxt;
            out2_d      = rd2_nxt;
            collision_d = coll_hit;
        end
    end

    always_ff @(posedge clk) begin
        out1_q      <= out1_d;
        out2_q      <= out2_d;
        collision_q <= collision_d;
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_cell
        regcell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .wsel (wsel[g]),
            .d_in (word_nxt[g]),
            .q_out(word_q[g])
        );
    end

    assign out1      = out1_q;
    assign out2      = out2_q;
    assign collision = collision_q;

endmodule

// File: doc/regfile_2w2r.md
REGFILE_2W2R -- requirements
Module: regfile_2w2r

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register word.
REQ-002 Parameter DEPTH, default 8, number of register words; legal range 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH), address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  global enable; 0 freezes all state including read outputs.
REQ-007 we1  input  1  write request, port 1.
REQ-008 mode1  input  1  port 1 write mode: 0 = overwrite, 1 = accumulate.
REQ-009 waddr1  input  AW  write address, port 1.
REQ-010 in1  input  WIDTH  write data, port 1.
REQ-011 we2, mode2, waddr2, in2  input  1/1/AW/WIDTH  same as port 1, for port 2.
REQ-012 raddr1, raddr2  input  AW  read addresses.
REQ-013 out1, out2  output  WIDTH  registered read data.
REQ-014 collision  output  1  registered one-cycle pulse when both ports write the same address.

Function
REQ-015 Writes and reads SHALL occur only on a clk edge with en=1 and rst=0.
REQ-016 Overwrite mode: word[waddr] <= in.
REQ-017 Accumulate mode: word[waddr] <= word[waddr] + in, modulo 2^WIDTH; carry is discarded and not flagged.
REQ-018 Two writes to different addresses in the same cycle SHALL both take effect.
REQ-019 Two writes to the same address in the same cycle: port 2 SHALL win, port 1 SHALL be dropped regardless of its mode, and collision SHALL be 1 on the next cycle.
REQ-020 collision SHALL otherwise be 0; it SHALL hold its value while en=0.
REQ-021 Read latency SHALL be one cycle: outN shows word[raddrN] as sampled at the edge.
REQ-022 Read-during-write to the same address SHALL be write-first: outN shows the post-write value, including the accumulated value.
REQ-023 An address >= DEPTH on a write SHALL be ignored; on a read, outN SHALL return 0.
REQ-024 With en=0, words, out1, out2 and collision SHALL hold their values; write requests are lost, not queued.

Reset
REQ-025 With rst=1 at a clk edge, all DEPTH words, out1, out2 and collision SHALL become 0.
REQ-026 rst SHALL take priority over en and over any write in the same cycle.
REQ-027 Reset asserted mid-operation SHALL discard any write in that cycle; the first write after reset SHALL see 0 as the accumulate base.

Structure
REQ-028 Package regfile_pkg SHALL hold the default WIDTH and DEPTH and the mode constants MODE_OVR=0 and MODE_ACC=1.
REQ-029 Sub-module regcell SHALL implement one word: clk, rst, en, write select, next-value input, and stored value output.
REQ-030 regfile_2w2r SHALL instantiate DEPTH regcells and contain the port arbitration, the accumulate adders and the read muxes.

Verification (WIDTH=8, DEPTH=8)
REQ-031 Reset, then read all 8 addresses -> every out1/out2 = 8'h00 and collision = 0.
REQ-032 Write port 1 addr 3 = 8'h9D in overwrite mode and port 2 addr 5 = 8'hBC in the same cycle; next cycle read raddr1=3, raddr2=5 -> out1 = 8'h9D, out2 = 8'hBC.
REQ-033 Addr 2 holds 8'hF0; port 1 accumulates 8'h20 -> addr 2 = 8'h10 (wrap); a same-cycle read of addr 2 -> out1 = 8'h10 one cycle later.
REQ-034 Both ports write addr 4 (in1 = 8'h11, in2 = 8'h22) -> addr 4 = 8'h22 and collision pulses 1 for exactly one cycle.
REQ-035 Apply en=0 while writing addr 1 = 8'hFF -> addr 1 keeps its old value and out1/out2 hold; raise en -> normal operation resumes.
REQ-036 Assert rst in the same cycle as a write of 8'hAA to addr 0 -> addr 0 = 8'h00; then accumulate 8'h05 to addr 0 -> addr 0 = 8'h05.
